// File: rtl/branch_unit_pkg.sv
// Shared types for the branch unit: condition codes, flag bit positions and FSM states.
package branch_unit_pkg;

    typedef enum logic [3:0] {
        COND_JMP = 4'd0,
        COND_JEQ = 4'd1,
        COND_JNE = 4'd2,
        COND_JGT = 4'd3,
        COND_JGE = 4'd4,
        COND_JLT = 4'd5,
        COND_JLE = 4'd6,
        COND_JCR = 4'd7,
        COND_JNC = 4'd8,
        COND_JOV = 4'd9,
        COND_JNV = 4'd10
    } cond_e;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HAZARD  = 2'd1,
        ST_RESOLVE = 2'd2
    } state_e;

endpackage

// File: rtl/branch_unit_cond.sv
// Combinational condition evaluator; codes outside the defined set are illegal and never taken.
module cond_check
    import branch_unit_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic [3:0] flags_i,
    output logic       taken_o,
    output logic       illegal_o
);

    logic z, n, c, v;

    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (code_i)
            COND_JMP: taken_o = 1'b1;
            COND_JEQ: taken_o = z;
            COND_JNE: taken_o = !z;
            COND_JGT: taken_o = !z && !n;
            COND_JGE: taken_o = !n;
            COND_JLT: taken_o = n;
            COND_JLE: taken_o = z || n;
            COND_JCR: taken_o = c;
            COND_JNC: taken_o = !c;
            COND_JOV: taken_o = v;
            COND_JNV: taken_o = !v;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Jump resolution unit: accepts a request, waits out a pending flag write if needed,
// then evaluates the condition and issues registered resolve / PC-load pulses.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             jmp_valid_i,
    output logic             jmp_ready_o,
    input  logic [3:0]       jmp_cond_i,
    input  logic [PC_W-1:0]  jmp_target_i,
    input  logic [3:0]       flags_i,
    input  logic             flags_upd_i,
    output logic             pc_load_o,
    output logic [PC_W-1:0]  pc_target_o,
    output logic             resolved_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] ntaken_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [3:0]        cond_q;
    logic [PC_W-1:0]   target_q;
    logic              accept, resolving, taken, illegal;

    // Ready is gated by reset so it reads 0 while the block is held in reset.
    assign jmp_ready_o = rst_ni && (state_q == ST_IDLE);
    assign accept      = jmp_valid_i && jmp_ready_o;
    assign resolving   = (state_q == ST_RESOLVE);

    cond_check u_cond (
        .code_i    (cond_q),
        .flags_i   (flags_i),
        .taken_o   (taken),
        .illegal_o (illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = flags_upd_i ? ST_HAZARD : ST_RESOLVE;
            ST_HAZARD:  state_d = ST_RESOLVE;
            ST_RESOLVE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cond_q   <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cond_q   <= jmp_cond_i;
                target_q <= jmp_target_i;
            end
        end
    end

    // Pulses and counters are updated at the edge closing RESOLVE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resolved_o   <= 1'b0;
            pc_load_o    <= 1'b0;
            illegal_o    <= 1'b0;
            pc_target_o  <= '0;
            taken_cnt_o  <= '0;
            ntaken_cnt_o <= '0;
        end else begin
            resolved_o  <= resolving;
            pc_load_o   <= resolving && taken;
            illegal_o   <= resolving && illegal;
            pc_target_o <= (resolving && taken) ? target_q : '0;
            if (resolving) begin
                if (taken) begin
                    if (taken_cnt_o != '1) taken_cnt_o <= taken_cnt_o + CNT_ONE;
                end else begin
                    if (ntaken_cnt_o != '1) ntaken_cnt_o <= ntaken_cnt_o + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit (built with CNT_W=4 so saturation is reachable).
module tb_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       jmp_valid;
    logic       jmp_ready;
    logic [3:0] jmp_cond;
    logic [7:0] jmp_target;
    logic [3:0] flags;
    logic       flags_upd;
    logic       pc_load;
    logic [7:0] pc_target;
    logic       resolved;
    logic       illegal;
    logic [3:0] taken_cnt;
    logic [3:0] ntaken_cnt;

    int total = 0;
    int bad   = 0;
    int exp_tcnt = 0;
    int exp_ncnt = 0;

    branch_unit #(.PC_W(8), .CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .jmp_valid_i  (jmp_valid),
        .jmp_ready_o  (jmp_ready),
        .jmp_cond_i   (jmp_cond),
        .jmp_target_i (jmp_target),
        .flags_i      (flags),
        .flags_upd_i  (flags_upd),
        .pc_load_o    (pc_load),
        .pc_target_o  (pc_target),
        .resolved_o   (resolved),
        .illegal_o    (illegal),
        .taken_cnt_o  (taken_cnt),
        .ntaken_cnt_o (ntaken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference condition table, written from the condition-code list.
    function automatic logic model_taken(input int code, input logic [3:0] f);
        logic z, n, c, v;
        z = f[3]; n = f[2]; c = f[1]; v = f[0];
        case (code)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return !z && !n;
            4:  return !n;
            5:  return n;
            6:  return z || n;
            7:  return c;
            8:  return !c;
            9:  return v;
            10: return !v;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check_output({tag, ".ready"},  32'(jmp_ready),  32'd0);
        check_output({tag, ".load"},   32'(pc_load),    32'd0);
        check_output({tag, ".res"},    32'(resolved),   32'd0);
        check_output({tag, ".ill"},    32'(illegal),    32'd0);
        check_output({tag, ".tgt"},    32'(pc_target),  32'd0);
        check_output({tag, ".tcnt"},   32'(taken_cnt),  32'd0);
        check_output({tag, ".ncnt"},   32'(ntaken_cnt), 32'd0);
    endtask

    // Issues one request from IDLE (called at posedge+1) and follows it to its pulse.
    task automatic apply_stimulus(input string tag, input logic [3:0] code, input logic [7:0] tgt,
                                  input logic [3:0] fl, input logic upd, input logic [3:0] fl_after,
                                  input logic exp_tk, input logic exp_il);
        jmp_valid  = 1'b1;
        jmp_cond   = code;
        jmp_target = tgt;
        flags      = fl;
        flags_upd  = upd;
        check_output({tag, ".ready"}, 32'(jmp_ready), 32'd1);
        @(posedge clk); #1;
        jmp_valid  = 1'b0;
        flags_upd  = 1'b0;
        flags      = fl_after;
        jmp_cond   = ~code;
        jmp_target = ~tgt;
        if (upd) begin
            check_output({tag, ".hz_ready"}, 32'(jmp_ready), 32'd0);
            check_output({tag, ".hz_res"},   32'(resolved),  32'd0);
            @(posedge clk); #1;
        end
        check_output({tag, ".rs_ready"}, 32'(jmp_ready), 32'd0);
        check_output({tag, ".rs_res"},   32'(resolved),  32'd0);
        @(posedge clk); #1;
        if (exp_tk) begin
            if (exp_tcnt < 15) exp_tcnt++;
        end else begin
            if (exp_ncnt < 15) exp_ncnt++;
        end
        check_output({tag, ".res"},  32'(resolved),   32'd1);
        check_output({tag, ".load"}, 32'(pc_load),    32'(exp_tk));
        check_output({tag, ".tgt"},  32'(pc_target),  exp_tk ? 32'(tgt) : 32'd0);
        check_output({tag, ".ill"},  32'(illegal),    32'(exp_il));
        check_output({tag, ".tcnt"}, 32'(taken_cnt),  32'(exp_tcnt));
        check_output({tag, ".ncnt"}, 32'(ntaken_cnt), 32'(exp_ncnt));
        check_output({tag, ".idle"}, 32'(jmp_ready),  32'd1);
    endtask

    initial begin
        rst_n = 1'b0; jmp_valid = 1'b0; jmp_cond = 4'd0; jmp_target = 8'd0;
        flags = 4'd0; flags_upd = 1'b0;
        #3;
        check_all_zero("reset");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("post_reset.ready", 32'(jmp_ready), 32'd1);

        // JEQ with Z set, no hazard: taken, target 0x2A
        apply_stimulus("jeq_taken", 4'd1, 8'h2A, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0);
        // JEQ with a pending flag write that clears Z: not taken, 3-cycle latency
        apply_stimulus("jeq_hazard", 4'd1, 8'h33, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0);
        check_output("jeq_hazard.ncnt1", 32'(ntaken_cnt), 32'd1);

        for (int code = 0; code < 16; code++) begin
            for (int f = 0; f < 16; f++) begin
                apply_stimulus($sformatf("sweep_c%0d_f%0h", code, f), 4'(code), 8'(code * 16 + f),
                               4'(f), 1'b0, 4'(f), model_taken(code, 4'(f)), code >= 11);
            end
        end

        // Back-to-back JMPs with valid held high: one resolution every two cycles.
        jmp_valid = 1'b1; jmp_cond = 4'd0; jmp_target = 8'h40; flags_upd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_output($sformatf("b2b%0d.rs_ready", i), 32'(jmp_ready), 32'd0);
            check_output($sformatf("b2b%0d.rs_res", i),   32'(resolved),  32'd0);
            jmp_target = 8'(8'h41 + i);
            @(posedge clk); #1;
            if (exp_tcnt < 15) exp_tcnt++;
            check_output($sformatf("b2b%0d.res", i),   32'(resolved),  32'd1);
            check_output($sformatf("b2b%0d.tgt", i),   32'(pc_target), 32'(8'h40 + i));
            check_output($sformatf("b2b%0d.ready", i), 32'(jmp_ready), 32'd1);
            check_output($sformatf("b2b%0d.tcnt", i),  32'(taken_cnt), 32'(exp_tcnt));
        end
        jmp_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("b2b.drained", 32'(resolved), 32'd0);

        // Reset while in HAZARD discards the request.
        jmp_valid = 1'b1; jmp_cond = 4'd0; jmp_target = 8'h77; flags_upd = 1'b1;
        @(posedge clk); #1;
        jmp_valid = 1'b0; flags_upd = 1'b0;
        check_output("rst_hz.ready", 32'(jmp_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_hz");
        exp_tcnt = 0; exp_ncnt = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("rst_rel.ready", 32'(jmp_ready), 32'd1);
        check_output("rst_rel.res0",  32'(resolved),  32'd0);
        @(posedge clk); #1;
        check_output("rst_rel.res1",  32'(resolved),  32'd0);
        check_output("rst_rel.load",  32'(pc_load),   32'd0);
        apply_stimulus("after_rst", 4'd0, 8'h5C, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);

        // Saturation: 20 more taken jumps on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus($sformatf("sat%0d", i), 4'd0, 8'(i), 4'b0101, 1'b0, 4'b0101, 1'b1, 1'b0);
        end
        check_output("sat.final_tcnt", 32'(taken_cnt),  32'hF);
        check_output("sat.final_ncnt", 32'(ntaken_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
